// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM state type and default widths.
package product_accumulator_pkg;

    localparam int DEF_A0_WIDTH    = 8;
    localparam int DEF_A1_WIDTH    = 8;
    localparam int DEF_ACC_WIDTH   = 24;
    localparam int DEF_COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_adder.sv
// Combinational unsigned adder that clamps to all ones and flags the carry-out.
module sat_adder
    import product_accumulator_pkg::*;
#(
    parameter int width = 8
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] sum,
    output logic             sat
);

    logic [width:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        sat  = full[width];
        sum  = full[width] ? '1 : full[width-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a burst of multiplier products into a saturating sum and presents
// the sum, term count and overflow flag on a valid/ready output handshake.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter  int a0_width      = DEF_A0_WIDTH,
    parameter  int a1_width      = DEF_A1_WIDTH,
    parameter  int acc_width     = DEF_ACC_WIDTH,
    parameter  int count_width   = DEF_COUNT_WIDTH,
    localparam int product_width = a0_width + a1_width
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [product_width-1:0] product,
    input  logic                     in_last,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [acc_width-1:0]     acc_out,
    output logic [count_width-1:0]   term_count,
    output logic                     overflow
);

    localparam logic [count_width-1:0] cnt_one = count_width'(1);

    state_t                 state, state_nxt;
    logic [acc_width-1:0]   acc_q, acc_nxt;
    logic [count_width-1:0] cnt_q, cnt_nxt;
    logic                   ovf_q, ovf_nxt;

    logic [acc_width-1:0]   product_ext;
    logic [acc_width-1:0]   acc_sum;
    logic                   acc_sat;
    logic [count_width-1:0] cnt_sum;
    logic                   cnt_sat_unused;
    logic                   accept;

    assign product_ext = acc_width'(product);
    assign accept      = in_valid && in_ready;

    sat_adder #(.width(acc_width)) u_acc_add (
        .a   (acc_q),
        .b   (product_ext),
        .sum (acc_sum),
        .sat (acc_sat)
    );

    // Term count clamps silently; its carry never contributes to overflow.
    sat_adder #(.width(count_width)) u_cnt_add (
        .a   (cnt_q),
        .b   (cnt_one),
        .sum (cnt_sum),
        .sat (cnt_sat_unused)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc_q;
        cnt_nxt   = cnt_q;
        ovf_nxt   = ovf_q;

        if (clear) begin
            state_nxt = ST_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc_nxt   = product_ext;
                        cnt_nxt   = cnt_one;
                        ovf_nxt   = 1'b0;
                        state_nxt = in_last ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_nxt = acc_sum;
                        cnt_nxt = cnt_sum;
                        ovf_nxt = ovf_q | acc_sat;
                        if (in_last) state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_nxt = ST_IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            endcase
        end
    end

    // Handshake and result outputs are registered copies keyed on the next
    // state, so the result ports read zero outside HOLD without extra gating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            acc_out    <= '0;
            term_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc_q     <= acc_nxt;
            cnt_q     <= cnt_nxt;
            ovf_q     <= ovf_nxt;
            in_ready  <= (state_nxt != ST_HOLD);
            out_valid <= (state_nxt == ST_HOLD);
            if (state_nxt == ST_HOLD) begin
                acc_out    <= acc_nxt;
                term_count <= cnt_nxt;
                overflow   <= ovf_nxt;
            end else begin
                acc_out    <= '0;
                term_count <= '0;
                overflow   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: a 24-bit and a 17-bit accumulator share one stimulus stream
// and are checked against hand-computed results from a vector table.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, clear, out_ready;
    logic [15:0] product;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [23:0] acc_a;
    logic [7:0]  cnt_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [16:0] acc_b;
    logic [7:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    product_accumulator dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .product(product), .in_last(in_last), .clear(clear),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .acc_out(acc_a), .term_count(cnt_a), .overflow(ovf_a)
    );

    product_accumulator #(.acc_width(17)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .product(product), .in_last(in_last), .clear(clear),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .acc_out(acc_b), .term_count(cnt_b), .overflow(ovf_b)
    );

    typedef struct {
        logic        v, l, cl, ord;
        logic [15:0] p;
        logic        ev;
        logic [23:0] ea;
        logic [16:0] eb;
        logic [7:0]  ec;
        logic        eoa, eob, er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t z(logic v, logic [15:0] p, logic l, logic cl, logic ord);
        vec_t r;
        r.v = v; r.p = p; r.l = l; r.cl = cl; r.ord = ord;
        r.ev = 1'b0; r.ea = '0; r.eb = '0; r.ec = '0; r.eoa = 1'b0; r.eob = 1'b0; r.er = 1'b1;
        return r;
    endfunction

    function automatic vec_t h(logic v, logic [15:0] p, logic l, logic cl, logic ord,
                               logic [23:0] ea, logic [16:0] eb, logic [7:0] ec,
                               logic eoa, logic eob);
        vec_t r;
        r.v = v; r.p = p; r.l = l; r.cl = cl; r.ord = ord;
        r.ev = 1'b1; r.ea = ea; r.eb = eb; r.ec = ec; r.eoa = eoa; r.eob = eob; r.er = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [23:0] ea,
                             input logic [16:0] eb, input logic [7:0] ec,
                             input logic eoa, input logic eob, input logic er);
        chk({tag, " a.out_valid"},  32'(out_valid_a), 32'(ev));
        chk({tag, " b.out_valid"},  32'(out_valid_b), 32'(ev));
        chk({tag, " a.in_ready"},   32'(in_ready_a),  32'(er));
        chk({tag, " b.in_ready"},   32'(in_ready_b),  32'(er));
        chk({tag, " a.acc_out"},    32'(acc_a),       32'(ea));
        chk({tag, " b.acc_out"},    32'(acc_b),       32'(eb));
        chk({tag, " a.term_count"}, 32'(cnt_a),       32'(ec));
        chk({tag, " b.term_count"}, 32'(cnt_b),       32'(ec));
        chk({tag, " a.overflow"},   32'(ovf_a),       32'(eoa));
        chk({tag, " b.overflow"},   32'(ovf_b),       32'(eob));
    endtask

    task automatic drive(input logic v, input logic [15:0] p, input logic l,
                         input logic cl, input logic ord);
        in_valid = v; product = p; in_last = l; clear = cl; out_ready = ord;
    endtask

    task automatic step(input logic v, input logic [15:0] p, input logic l,
                        input logic cl, input logic ord);
        drive(v, p, l, cl, ord);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 9+16+25 with out_ready high: result held exactly one cycle
        tbl.push_back(z(1, 16'd9,  0, 0, 1));
        tbl.push_back(z(1, 16'd16, 0, 0, 1));
        tbl.push_back(h(1, 16'd25, 1, 0, 1, 24'd50, 17'd50, 8'd3, 0, 0));
        tbl.push_back(z(0, 16'd0,  0, 0, 1));
        // single word, consumer stalls five cycles; offered words must be ignored
        tbl.push_back(h(1, 16'hFFFF, 1, 0, 0, 24'hFFFF, 17'hFFFF, 8'd1, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(h(1, 16'd1, 0, 0, 0, 24'hFFFF, 17'hFFFF, 8'd1, 0, 0));
        tbl.push_back(z(1, 16'd2, 1, 0, 1));
        tbl.push_back(z(0, 16'd0, 0, 0, 0));
        // exactly fills 17 bits: no overflow on either width
        tbl.push_back(z(1, 16'hFFFF, 0, 0, 0));
        tbl.push_back(z(1, 16'hFFFF, 0, 0, 0));
        tbl.push_back(h(1, 16'd1, 1, 0, 1, 24'h1FFFF, 17'h1FFFF, 8'd3, 0, 0));
        tbl.push_back(z(0, 16'd0, 0, 0, 1));
        // one more than 17 bits holds
        tbl.push_back(z(1, 16'hFFFF, 0, 0, 0));
        tbl.push_back(z(1, 16'hFFFF, 0, 0, 0));
        tbl.push_back(z(1, 16'd1,    0, 0, 0));
        tbl.push_back(h(1, 16'd1, 1, 0, 1, 24'h20000, 17'h1FFFF, 8'd4, 0, 1));
        tbl.push_back(z(0, 16'd0, 0, 0, 1));
        // overflow on the third word, sticky across a carry-free fourth
        tbl.push_back(z(1, 16'hFFFF, 0, 0, 0));
        tbl.push_back(z(1, 16'hFFFF, 0, 0, 0));
        tbl.push_back(z(1, 16'd2,    0, 0, 0));
        tbl.push_back(h(1, 16'd0, 1, 0, 1, 24'h20000, 17'h1FFFF, 8'd4, 0, 1));
        tbl.push_back(z(0, 16'd0, 0, 0, 1));
        // clear together with an accepted word in ACCUM, then a burst of seven ones
        tbl.push_back(z(1, 16'd5, 0, 0, 0));
        tbl.push_back(z(1, 16'd7, 0, 1, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(z(1, 16'd1, 0, 0, 0));
        tbl.push_back(h(1, 16'd1, 1, 0, 1, 24'd7, 17'd7, 8'd7, 0, 0));
        tbl.push_back(z(0, 16'd0, 0, 0, 1));
        // clear drops a held result
        tbl.push_back(h(1, 16'd3, 1, 0, 0, 24'd3, 17'd3, 8'd1, 0, 0));
        tbl.push_back(z(1, 16'd9, 0, 1, 0));
        tbl.push_back(z(0, 16'd0, 0, 0, 0));
        // clear in IDLE discards a would-be single-word burst
        tbl.push_back(z(1, 16'd8, 1, 1, 1));
        // back-to-back single-word bursts: HOLD cycle refuses the second word
        tbl.push_back(h(1, 16'd4, 1, 0, 1, 24'd4, 17'd4, 8'd1, 0, 0));
        tbl.push_back(z(1, 16'd6, 1, 0, 1));
        tbl.push_back(h(1, 16'd6, 1, 0, 1, 24'd6, 17'd6, 8'd1, 0, 0));
        tbl.push_back(z(0, 16'd0, 0, 0, 1));

        rst_n = 1'b0;
        drive(0, 16'd0, 0, 0, 0);
        #12;
        check_out("reset", 0, '0, '0, '0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_reset", 0, '0, '0, '0, 0, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].cl, tbl[i].ord);
            check_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].eb,
                      tbl[i].ec, tbl[i].eoa, tbl[i].eob, tbl[i].er);
        end

        // 300 ones: term count clamps at 255, sum keeps counting, no overflow
        for (int i = 0; i < 300; i++) begin
            step(1, 16'd1, (i == 299), 0, 0);
            if (i == 298) chk("burst300 mid out_valid", 32'(out_valid_a), 32'd0);
        end
        check_out("burst300", 1, 24'd300, 17'd300, 8'd255, 0, 0, 0);
        step(0, 16'd0, 0, 0, 1);
        check_out("burst300_done", 0, '0, '0, '0, 0, 0, 1);

        // asynchronous reset in the middle of HOLD
        step(1, 16'h1234, 1, 0, 0);
        check_out("pre_async", 1, 24'h1234, 17'h1234, 8'd1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 0, '0, '0, '0, 0, 0, 0);
        #3;
        rst_n = 1'b1;
        drive(0, 16'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_out("async_release", 0, '0, '0, '0, 0, 0, 1);
        step(1, 16'd10, 0, 0, 0);
        step(1, 16'd20, 1, 0, 1);
        check_out("after_reset_burst", 1, 24'd30, 17'd30, 8'd2, 0, 0, 0);
        step(0, 16'd0, 0, 0, 1);
        check_out("after_reset_idle", 0, '0, '0, '0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
